// File: rtl/pipelined_reduce_gate.sv
// Masked AND/OR/XOR reduction of WIDTH bits through a registered GROUP-ary tree,
// carrying a valid flag alongside and counting asserted valid results.
module pipelined_reduce_gate #(
  parameter int WIDTH  = 12,
  parameter int GROUP  = 4,
  parameter int OP     = 0,
  parameter int INVERT = 0,
  parameter int CNTW   = 8
) (
  input  logic             CK,
  input  logic             CD,
  input  logic             CE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] M,
  input  logic             VI,
  input  logic             CLR,
  output logic             Z0,
  output logic             VO,
  output logic [CNTW-1:0]  HITS
);

  // Smallest k >= 1 with g**k >= w; the loop bound covers WIDTH=256, GROUP=2.
  function automatic int calc_levels(input int w, input int g);
    int k;
    int span;
    k = 1;
    span = g;
    for (int i = 0; i < 16; i++) begin
      if (span < w) begin
        span = span * g;
        k = k + 1;
      end
    end
    return k;
  endfunction

  localparam int   LEVELS = calc_levels(WIDTH, GROUP);
  localparam int   PADW   = GROUP ** LEVELS;
  localparam logic IDENT  = (OP == 0);

  if (OP < 0 || OP > 2) begin : g_bad_op
    $error("pipelined_reduce_gate: OP must be 0 (AND), 1 (OR) or 2 (XOR)");
  end
  if (WIDTH < 1 || WIDTH > 256 || GROUP < 2 || GROUP > 8) begin : g_bad_size
    $error("pipelined_reduce_gate: WIDTH must be 1..256 and GROUP 2..8");
  end

  function automatic logic reduce_node(input logic [GROUP-1:0] v);
    logic r;
    case (OP)
      1:       r = |v;
      2:       r = ^v;
      default: r = &v;
    endcase
    return r;
  endfunction

  genvar gi;

  // Masked bits and tree padding both take the identity, so they never
  // influence the result.
  logic [PADW-1:0] lvl0;
  for (gi = 0; gi < PADW; gi++) begin : g_pad
    if (gi < WIDTH) begin : g_data
      assign lvl0[gi] = M[gi] ? IDENT : A[gi];
    end else begin : g_fill
      assign lvl0[gi] = IDENT;
    end
  end

  for (gi = 1; gi <= LEVELS; gi++) begin : lvl_g
    localparam int NODES = GROUP ** (LEVELS - gi);
    logic [NODES*GROUP-1:0] src;
    logic [NODES-1:0]       lvl_d;
    logic [NODES-1:0]       lvl_q;

    if (gi == 1) begin : g_src
      assign src = lvl0;
    end else begin : g_src
      assign src = lvl_g[gi-1].lvl_q;
    end

    always_comb begin
      lvl_d = '0;
      for (int n = 0; n < NODES; n++) begin
        lvl_d[n] = reduce_node(src[n*GROUP +: GROUP]);
      end
      if (gi == LEVELS && INVERT != 0) begin
        lvl_d = ~lvl_d;
      end
    end

    always_ff @(posedge CK or posedge CD) begin
      if (CD) begin
        lvl_q <= '0;
      end else if (CE) begin
        lvl_q <= lvl_d;
      end
    end
  end

  logic [LEVELS-1:0] vld_d;
  logic [LEVELS-1:0] vld_q;
  logic [CNTW-1:0]   hits_d;
  logic [CNTW-1:0]   hits_q;

  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = VI;
  end

  // Counter looks at the registered outputs, so it trails Z0/VO by a cycle.
  always_comb begin
    hits_d = hits_q;
    if (CLR) begin
      hits_d = '0;
    end else if (VO && Z0 && (hits_q != {CNTW{1'b1}})) begin
      hits_d = hits_q + CNTW'(1);
    end
  end

  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      vld_q  <= '0;
      hits_q <= '0;
    end else if (CE) begin
      vld_q  <= vld_d;
      hits_q <= hits_d;
    end
  end

  assign Z0   = lvl_g[LEVELS].lvl_q[0];
  assign VO   = vld_q[LEVELS-1];
  assign HITS = hits_q;

endmodule

// File: tb/tb_pipelined_reduce_gate.sv
// Bench for pipelined_reduce_gate: five configurations share one stimulus bus;
// a scoreboard tracks every valid through each pipeline and its hit counter.
module tb_pipelined_reduce_gate;

  localparam int NI = 5;
  // Instances: 0=AND12 (CNTW=4), 1=OR12, 2=XNOR12, 3=AND1/G2, 4=XOR17/G4
  localparam int WD   [0:NI-1] = '{12, 12, 12, 1, 17};
  localparam int OPS  [0:NI-1] = '{0, 1, 2, 0, 2};
  localparam int INV  [0:NI-1] = '{0, 0, 1, 0, 0};
  localparam int LAT  [0:NI-1] = '{2, 2, 2, 1, 3};
  localparam int HMAX [0:NI-1] = '{15, 255, 255, 255, 255};

  typedef struct {
    logic [11:0] a;
    logic [11:0] m;
    logic        z_and;
    logic        z_or;
    logic        z_xn;
  } vec_t;

  typedef struct {
    int   inst;
    int   due;
    logic z;
  } sb_t;

  logic        CK = 1'b0;
  logic        CD;
  logic        CE;
  logic        VI;
  logic        CLR;
  logic [16:0] a_bus;
  logic [16:0] m_bus;
  logic [NI-1:0] z_w;
  logic [NI-1:0] vo_w;
  logic [3:0]  h0;
  logic [7:0]  h1, h2, h3, h4;

  vec_t          tbl [12];
  sb_t           sb [$];
  int            ecnt;
  int            hits_m [NI];
  logic [NI-1:0] ev_r, ez_r, cur_exp;
  int            nvec = 0;
  int            nerr = 0;

  always #5 CK = ~CK;

  pipelined_reduce_gate #(.WIDTH(12), .GROUP(4), .OP(0), .INVERT(0), .CNTW(4)) u_and (
    .CK(CK), .CD(CD), .CE(CE), .A(a_bus[11:0]), .M(m_bus[11:0]), .VI(VI), .CLR(CLR),
    .Z0(z_w[0]), .VO(vo_w[0]), .HITS(h0));
  pipelined_reduce_gate #(.WIDTH(12), .GROUP(4), .OP(1), .INVERT(0), .CNTW(8)) u_or (
    .CK(CK), .CD(CD), .CE(CE), .A(a_bus[11:0]), .M(m_bus[11:0]), .VI(VI), .CLR(CLR),
    .Z0(z_w[1]), .VO(vo_w[1]), .HITS(h1));
  pipelined_reduce_gate #(.WIDTH(12), .GROUP(4), .OP(2), .INVERT(1), .CNTW(8)) u_xn (
    .CK(CK), .CD(CD), .CE(CE), .A(a_bus[11:0]), .M(m_bus[11:0]), .VI(VI), .CLR(CLR),
    .Z0(z_w[2]), .VO(vo_w[2]), .HITS(h2));
  pipelined_reduce_gate #(.WIDTH(1), .GROUP(2), .OP(0), .INVERT(0), .CNTW(8)) u_w1 (
    .CK(CK), .CD(CD), .CE(CE), .A(a_bus[0:0]), .M(m_bus[0:0]), .VI(VI), .CLR(CLR),
    .Z0(z_w[3]), .VO(vo_w[3]), .HITS(h3));
  pipelined_reduce_gate #(.WIDTH(17), .GROUP(4), .OP(2), .INVERT(0), .CNTW(8)) u_w17 (
    .CK(CK), .CD(CD), .CE(CE), .A(a_bus), .M(m_bus), .VI(VI), .CLR(CLR),
    .Z0(z_w[4]), .VO(vo_w[4]), .HITS(h4));

  function automatic logic [31:0] get_hits(input int k);
    case (k)
      0:       return {28'h0, h0};
      1:       return {24'h0, h1};
      2:       return {24'h0, h2};
      3:       return {24'h0, h3};
      default: return {24'h0, h4};
    endcase
  endfunction

  // Flat reduction over the unmasked bits, straight from the gate definition.
  function automatic logic model(input int k, input logic [16:0] a, input logic [16:0] m);
    logic acc;
    acc = (OPS[k] == 0);
    for (int i = 0; i < WD[k]; i++) begin
      if (!m[i]) begin
        case (OPS[k])
          0:       acc = acc & a[i];
          1:       acc = acc | a[i];
          default: acc = acc ^ a[i];
        endcase
      end
    end
    return acc ^ (INV[k] != 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int   idx;
    logic ev, ez;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due < ecnt) sb.delete(i);
    end
    for (int k = 0; k < NI; k++) begin
      idx = -1;
      for (int i = 0; i < sb.size(); i++) begin
        if (idx < 0 && sb[i].inst == k) idx = i;
      end
      ev = (idx >= 0) && (sb[idx].due == ecnt);
      ez = ev ? sb[idx].z : 1'b0;
      chk($sformatf("vo%0d", k), {31'h0, vo_w[k]}, {31'h0, ev});
      if (ev) chk($sformatf("z0_%0d", k), {31'h0, z_w[k]}, {31'h0, ez});
      chk($sformatf("hits%0d", k), get_hits(k), hits_m[k]);
      ev_r[k] = ev;
      ez_r[k] = ez;
    end
  endtask

  task automatic tick();
    sb_t e;
    @(posedge CK);
    if (!CD && CE) begin
      for (int k = 0; k < NI; k++) begin
        if (CLR) hits_m[k] = 0;
        else if (ev_r[k] && ez_r[k] && hits_m[k] < HMAX[k]) hits_m[k]++;
        if (VI) begin
          e.inst = k;
          e.due  = ecnt + LAT[k];
          e.z    = cur_exp[k];
          sb.push_back(e);
        end
      end
      ecnt++;
    end
    @(negedge CK);
    check_outputs();
  endtask

  task automatic drive(input logic [16:0] a, input logic [16:0] m, input logic vi,
                       input logic ce, input logic clr, input logic [2:0] tz, input bit use_tbl);
    a_bus = a;
    m_bus = m;
    VI    = vi;
    CE    = ce;
    CLR   = clr;
    for (int k = 0; k < NI; k++) cur_exp[k] = model(k, a, m);
    if (use_tbl) cur_exp[2:0] = tz;
    $display("vec a=%05h m=%05h vi=%b ce=%b clr=%b exp=%b", a, m, vi, ce, clr, cur_exp);
    tick();
  endtask

  task automatic drive_tbl(input int i, input logic ce);
    drive({tbl[i].a[11:7], tbl[i].a}, {5'h0, tbl[i].m}, 1'b1, ce, 1'b0,
          {tbl[i].z_xn, tbl[i].z_or, tbl[i].z_and}, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(17'h0, 17'h0, 1'b0, 1'b1, 1'b0, 3'b0, 1'b0);
  endtask

  task automatic async_reset();
    CD = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("cd_vo%0d", k), {31'h0, vo_w[k]}, 32'h0);
      chk($sformatf("cd_z0_%0d", k), {31'h0, z_w[k]}, 32'h0);
      chk($sformatf("cd_hits%0d", k), get_hits(k), 32'h0);
      hits_m[k] = 0;
    end
    sb.delete();
    ev_r = '0;
    ez_r = '0;
  endtask

  initial begin
    // {a, m, AND, OR, XNOR} hand-derived for the 12-bit instances
    tbl[0]  = '{12'hFFF, 12'h000, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{12'hFFE, 12'h000, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{12'h7FF, 12'h800, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{12'h000, 12'hFFF, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{12'h007, 12'h000, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{12'h00F, 12'h000, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{12'h000, 12'h000, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{12'hFFF, 12'h000, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{12'hF0F, 12'h0F0, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{12'h0F0, 12'h0F0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{12'h800, 12'h000, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{12'h123, 12'h000, 1'b0, 1'b1, 1'b1};

    CD = 1'b0; CE = 1'b1; VI = 1'b0; CLR = 1'b0;
    a_bus = '0; m_bus = '0;
    ecnt = 0; ev_r = '0; ez_r = '0; cur_exp = '0;
    for (int k = 0; k < NI; k++) hits_m[k] = 0;

    #1;
    async_reset();
    idle(2);
    CD = 1'b0;
    idle(2);

    // Table vectors streamed back to back, including XNOR popcounts 3,4,0,12
    for (int i = 0; i < 12; i++) drive_tbl(i, 1'b1);
    idle(4);

    // Three-cycle CE stall in the middle of a stream
    for (int i = 0; i < 5; i++) drive_tbl(i + 4, 1'b1);
    for (int i = 0; i < 3; i++) drive(17'h1ABCD, 17'h0, 1'b0, 1'b0, 1'b0, 3'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_tbl(i + 8, 1'b1);
    idle(4);

    // Counter saturation, CLR against a hit, CLR ignored under CE=0
    drive(17'h0, 17'h0, 1'b0, 1'b1, 1'b1, 3'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(17'h1FFFF, 17'h0, 1'b1, 1'b1, 1'b0, 3'b0, 1'b0);
    idle(4);
    chk("and_hits_sat", get_hits(0), 32'd15);
    drive(17'h1FFFF, 17'h0, 1'b1, 1'b1, 1'b0, 3'b0, 1'b0);
    drive(17'h1FFFF, 17'h0, 1'b1, 1'b1, 1'b0, 3'b0, 1'b0);
    drive(17'h1FFFF, 17'h0, 1'b1, 1'b1, 1'b1, 3'b0, 1'b0);
    chk("and_clr_over_hit", get_hits(0), 32'd0);
    idle(2);
    chk("and_hits_after_clr", get_hits(0), 32'd2);
    drive(17'h0, 17'h0, 1'b0, 1'b0, 1'b1, 3'b0, 1'b0);
    chk("and_clr_ce0", get_hits(0), 32'd2);
    idle(4);

    // Reset with valids in flight, then confirm nothing stale emerges
    drive(17'h1FFFF, 17'h0, 1'b1, 1'b1, 1'b0, 3'b0, 1'b0);
    drive(17'h1FFFF, 17'h0, 1'b1, 1'b1, 1'b0, 3'b0, 1'b0);
    #2;
    async_reset();
    idle(2);
    CD = 1'b0;
    idle(4);
    drive_tbl(0, 1'b1);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
